jtframe_kabuki_enc: RTL
=======================

Name: jtframe_kabuki_enc

Overview:
- Kabuki encryptor: the exact inverse of the codebase's Z80 Kabuki opcode/data decoder.
- Takes plaintext bytes tagged with address and fetch type, and produces the cipher bytes the decoder maps back to the plaintext.
- Used to re-encrypt patched program ROMs during download and to generate golden vectors for decoder benches.
- Streaming block: valid/ready on both sides, 3-stage pipeline, keys loaded serially over the same prog interface as the decoder.

Parameters:
- XOR_DATA, 16'h1fc0, address XOR mask applied to data (non-opcode) fetches.

Ports:
- clk  in  1  system clock, same as the SDRAM/decoder clock.
- rst  in  1  asynchronous, active-high reset.
- prog_data  in  8  key byte.
- prog_we  in  1  key byte strobe, one byte per cycle while high.
- key_ok  out  1  all 11 key bytes loaded.
- en  in  1  1 = encrypt, 0 = pass data through unchanged; sampled with each accepted input.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_m1  in  1  1 = opcode fetch, 0 = data fetch.
- in_addr  in  16  Z80 address of the byte.
- in_data  in  8  plaintext byte.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_addr  out  16  in_addr, delayed with the data.
- out_m1  out  1  in_m1, delayed with the data.
- out_data  out  8  cipher byte.

Behaviour:
- Reset: clears all key bits, the byte counter (4 bits) and every pipeline valid bit. key_ok=0, out_valid=0, out_data=0, out_addr=0, out_m1=0.
- Key load:
  - Bytes shift into an 88-bit register from the LSB side, so the first byte ends up in bits 87:80.
  - Field split: swap_key1 = [87:56], swap_key2 = [55:24], addr_key = [23:8], xor_key = [7:0].
  - The counter increments per prog_we; key_ok goes to 1 the cycle after the 11th byte.
  - prog_we while key_ok=1 starts a new load: the counter restarts at 1 with that byte, key_ok drops to 0 the next cycle, and all pipeline valid bits clear that same edge. Outputs in flight are discarded.
- Handshake:
  - in_ready = key_ok && !prog_we && (!out_valid || out_ready).
  - The whole pipeline advances only when out_valid=0 or out_ready=1; otherwise every stage holds.
  - Latency is exactly 3 advancing cycles from acceptance to out_valid. Sustained throughput is 1 byte/cycle.
- Stage 1: register the hit word H.
  - Opcode fetch: H = in_addr + addr_key.
  - Data fetch: H = (in_addr ^ XOR_DATA) + addr_key + 1.
  - Both sums are modulo 2^16 and drop the carry.
  - Stage 1 also registers data, en, m1 and addr.
- Primitive operations (b = byte, k = 16-bit key, h = 8-bit hit byte; pair p means bits {2p+1, 2p}, p = 0..3):
  - swapA(b,k,h): swap pair p when h[k[4p+2:4p]]=1.
  - swapB(b,k,h): swap pair p when h[k[4(3-p)+2:4(3-p)]]=1.
  - ror(b) = {b[0], b[7:1]}.
- Stage 2, using hh = H[15:8]: b = swapA(b, swap_key2[31:16], hh); b = ror(b); b = swapB(b, swap_key2[15:0], hh); b = ror(b).
- Stage 3, using hl = H[7:0]: b = b ^ xor_key; b = swapB(b, swap_key1[31:16], hl); b = ror(b); b = swapA(b, swap_key1[15:0], hl). The result registers into out_data.
- en=0 at acceptance: the byte passes through all 3 stages unmodified, with the same latency.
- Keys are used live. They are stable whenever data is in flight, because any reload flushes the pipeline.

Test Plan:
- Load 11 zero bytes; send m1=1, addr=0x0000, data=0x01 -> out_data=0x20 after 3 cycles; key_ok was high the cycle after the 11th byte.
- Zero keys; m1=0, addr=0x0000, data=0x01 -> H=0x1fc1, out_data=0x02.
- Keys zero except xor_key=0xFF (byte 11); m1=1, addr=0, data=0x00 -> out_data=0xFF. With en=0 -> out_data=0x00.
- Random keys, 10k random (m1, addr, data) streamed with random out_ready stalls -> the decoder model run on the outputs returns the inputs; order is preserved; no loss or duplication; 1 byte/cycle when out_ready is held at 1.
- Reload: prog_we while 3 bytes are in flight -> out_valid=0 the next cycle, in_ready=0 until 11 new bytes are loaded, no stale output.
- Assert rst with the pipeline full -> all outputs 0 immediately; key_ok=0; after release, in_ready stays 0 until the keys are reloaded.

Source files
------------

// File: rtl/jtframe_kabuki_enc.sv
// Kabuki encryptor: streaming inverse of the Z80 Kabuki opcode/data decoder.
// Plaintext bytes tagged with address and fetch type go in, cipher bytes come
// out three advancing cycles later. Keys load serially over prog_data/prog_we.
module jtframe_kabuki_enc #(
   parameter logic [15:0] XOR_DATA = 16'h1fc0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  prog_data,
   input  logic        prog_we,
   output logic        key_ok,
   input  logic        en,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_m1,
   input  logic [15:0] in_addr,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_addr,
   output logic        out_m1,
   output logic [7:0]  out_data
);

   // Swap bit pair p when the hit bit selected by key nibble p is set
   function automatic logic [7:0] swap_a(input logic [7:0] b, input logic [15:0] k,
                                         input logic [7:0] h);
      logic [7:0] r;
      r = b;
      for (int p = 0; p < 4; p++) begin
         if (h[k[4*p +: 3]]) begin
            r[2*p]   = b[2*p+1];
            r[2*p+1] = b[2*p];
         end
      end
      return r;
   endfunction

   // Same as swap_a but pair p is controlled by nibble 3-p
   function automatic logic [7:0] swap_b(input logic [7:0] b, input logic [15:0] k,
                                         input logic [7:0] h);
      logic [7:0] r;
      r = b;
      for (int p = 0; p < 4; p++) begin
         if (h[k[4*(3-p) +: 3]]) begin
            r[2*p]   = b[2*p+1];
            r[2*p+1] = b[2*p];
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] ror(input logic [7:0] b);
      return {b[0], b[7:1]};
   endfunction

   logic [87:0] key;
   logic [3:0]  cnt;
   logic [31:0] swap_key1;
   logic [31:0] swap_key2;
   logic [15:0] addr_key;
   logic [7:0]  xor_key;

   assign swap_key1 = key[87:56];
   assign swap_key2 = key[55:24];
   assign addr_key  = key[23:8];
   assign xor_key   = key[7:0];

   logic advance;
   logic accept;

   assign advance  = !out_valid || out_ready;
   assign in_ready = key_ok && !prog_we && advance;
   assign accept   = in_valid && in_ready;

   logic        s1_valid, s1_en, s1_m1;
   logic [15:0] s1_hit, s1_addr;
   logic [7:0]  s1_data;
   logic        s2_valid, s2_en, s2_m1;
   logic [15:0] s2_addr;
   logic [7:0]  s2_hl, s2_data;

   logic [15:0] hit_calc;
   logic [7:0]  s2_calc;
   logic [7:0]  out_calc;

   // Key shift register and byte counter; a byte arriving with a full key starts over
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key    <= '0;
         cnt    <= '0;
         key_ok <= 1'b0;
      end else if (prog_we) begin
         key <= {key[79:0], prog_data};
         if (key_ok) begin
            cnt    <= 4'd1;
            key_ok <= 1'b0;
         end else begin
            cnt    <= cnt + 4'd1;
            key_ok <= (cnt == 4'd10);
         end
      end
   end

   // Hit word: opcode fetches use the raw address, data fetches the masked one plus one
   always_comb begin
      hit_calc = in_addr + addr_key;
      if (!in_m1) begin
         hit_calc = (in_addr ^ XOR_DATA) + addr_key + 16'd1;
      end
   end

   // Upper hit byte drives the first half of the permutation
   always_comb begin
      s2_calc = s1_data;
      if (s1_en) begin
         s2_calc = ror(swap_b(ror(swap_a(s1_data, swap_key2[31:16], s1_hit[15:8])),
                              swap_key2[15:0], s1_hit[15:8]));
      end
   end

   // Lower hit byte drives the XOR and second half of the permutation
   always_comb begin
      out_calc = s2_data;
      if (s2_en) begin
         out_calc = swap_a(ror(swap_b(s2_data ^ xor_key, swap_key1[31:16], s2_hl)),
                           swap_key1[15:0], s2_hl);
      end
   end

   // Valid bits move only when the output can advance; any key byte flushes the pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (prog_we) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         s1_valid  <= accept;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
      end
   end

   // Payload registers follow the same advance enable as the valid bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_hit   <= '0;
         s1_addr  <= '0;
         s1_data  <= '0;
         s1_en    <= 1'b0;
         s1_m1    <= 1'b0;
         s2_hl    <= '0;
         s2_addr  <= '0;
         s2_data  <= '0;
         s2_en    <= 1'b0;
         s2_m1    <= 1'b0;
         out_addr <= '0;
         out_data <= '0;
         out_m1   <= 1'b0;
      end else if (advance) begin
         s1_hit   <= hit_calc;
         s1_addr  <= in_addr;
         s1_data  <= in_data;
         s1_en    <= en;
         s1_m1    <= in_m1;
         s2_hl    <= s1_hit[7:0];
         s2_addr  <= s1_addr;
         s2_data  <= s2_calc;
         s2_en    <= s1_en;
         s2_m1    <= s1_m1;
         out_addr <= s2_addr;
         out_data <= out_calc;
         out_m1   <= s2_m1;
      end
   end

endmodule
